// File: rtl/regfile_preload_pkg.sv
// Shared constants and state encoding for the regfile preloader, also used by
// the processor and the bench harness.
package regfile_preload_pkg;

  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned REG_BITS      = 5;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned RELEASE_DELAY = 2;
  localparam int unsigned COUNT_BITS    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

endpackage

// File: rtl/regfile_preload.sv
// Clears r1..r(NUM_REGS-1), streams initial register values into the regfile,
// then releases the processor and passes its write port straight through.
module regfile_preload #(
  parameter int unsigned NUM_REGS      = regfile_preload_pkg::NUM_REGS,
  parameter int unsigned REG_BITS      = regfile_preload_pkg::REG_BITS,
  parameter int unsigned DATA_WIDTH    = regfile_preload_pkg::DATA_WIDTH,
  parameter int unsigned RELEASE_DELAY = regfile_preload_pkg::RELEASE_DELAY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_BITS-1:0]   in_reg,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  cpu_we,
  input  logic [REG_BITS-1:0]   cpu_wreg,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  rf_we,
  output logic [REG_BITS-1:0]   rf_wreg,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  r0_drop,
  output logic [5:0]            load_count
);

  import regfile_preload_pkg::*;

  localparam logic [REG_BITS-1:0] LAST_REG  = REG_BITS'(NUM_REGS - 1);
  localparam logic [REG_BITS-1:0] HOLD_INIT = REG_BITS'(RELEASE_DELAY);
  localparam logic [REG_BITS-1:0] ONE       = REG_BITS'(1);
  localparam logic [5:0]          COUNT_MAX = '1;

  state_t                state, state_n;
  logic [REG_BITS-1:0]   counter, counter_n;
  logic                  rf_we_q, rf_we_n;
  logic [REG_BITS-1:0]   rf_wreg_q, rf_wreg_n;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_n;
  logic                  r0_drop_q, r0_drop_n;
  logic [5:0]            load_count_q, load_count_n;
  logic                  busy_q, done_q;

  always_comb begin
    state_n      = state;
    counter_n    = counter;
    rf_we_n      = 1'b0;
    rf_wreg_n    = rf_wreg_q;
    rf_wdata_n   = rf_wdata_q;
    r0_drop_n    = r0_drop_q;
    load_count_n = load_count_q;

    unique case (state)
      ST_IDLE, ST_RUN: begin
        // The r1 clear write is issued on the start edge so it lands one edge later.
        if (start) begin
          state_n      = ST_CLEAR;
          counter_n    = ONE;
          rf_we_n      = 1'b1;
          rf_wreg_n    = ONE;
          rf_wdata_n   = '0;
          r0_drop_n    = 1'b0;
          load_count_n = '0;
        end
      end
      ST_CLEAR: begin
        if (counter == LAST_REG) begin
          state_n = ST_LOAD;
        end else begin
          counter_n  = counter + ONE;
          rf_we_n    = 1'b1;
          rf_wreg_n  = counter + ONE;
          rf_wdata_n = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          rf_we_n    = (in_reg != '0);
          rf_wreg_n  = in_reg;
          rf_wdata_n = in_data;
          if (in_reg == '0) r0_drop_n = 1'b1;
          if (load_count_q != COUNT_MAX) load_count_n = load_count_q + 6'd1;
          if (in_last) begin
            state_n   = ST_HOLD;
            counter_n = HOLD_INIT;
          end
        end
      end
      ST_HOLD: begin
        if (counter <= ONE) state_n = ST_RUN;
        else counter_n = counter - ONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      rf_we_q      <= 1'b0;
      rf_wreg_q    <= '0;
      rf_wdata_q   <= '0;
      r0_drop_q    <= 1'b0;
      load_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      counter      <= counter_n;
      rf_we_q      <= rf_we_n;
      rf_wreg_q    <= rf_wreg_n;
      rf_wdata_q   <= rf_wdata_n;
      r0_drop_q    <= r0_drop_n;
      load_count_q <= load_count_n;
      busy_q       <= (state_n == ST_CLEAR) || (state_n == ST_LOAD) || (state_n == ST_HOLD);
      done_q       <= (state_n == ST_RUN);
    end
  end

  assign in_ready   = (state == ST_LOAD);
  assign cpu_reset  = (state != ST_RUN);
  assign busy       = busy_q;
  assign done       = done_q;
  assign r0_drop    = r0_drop_q;
  assign load_count = load_count_q;

  assign rf_we    = (state == ST_RUN) ? cpu_we    : rf_we_q;
  assign rf_wreg  = (state == ST_RUN) ? cpu_wreg  : rf_wreg_q;
  assign rf_wdata = (state == ST_RUN) ? cpu_wdata : rf_wdata_q;

endmodule

// File: tb/tb_regfile_preload.sv
// Bench for regfile_preload: harness regfile on rf_*, expected contents from a
// last-beat-wins array model of the load stream.
module tb_regfile_preload;
  import regfile_preload_pkg::*;

  localparam int RD = 2;

  logic                  clock = 1'b0;
  logic                  reset, start, in_valid, in_ready, in_last;
  logic [REG_BITS-1:0]   in_reg, cpu_wreg, rf_wreg;
  logic [DATA_WIDTH-1:0] in_data, cpu_wdata, rf_wdata;
  logic                  cpu_we, rf_we, cpu_reset, busy, done, r0_drop;
  logic [5:0]            load_count;
  logic                  preset;

  regfile_preload #(
    .NUM_REGS(NUM_REGS), .REG_BITS(REG_BITS), .DATA_WIDTH(DATA_WIDTH), .RELEASE_DELAY(RD)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data), .in_last(in_last),
    .cpu_we(cpu_we), .cpu_wreg(cpu_wreg), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .r0_drop(r0_drop), .load_count(load_count)
  );

  always #5 clock = ~clock;

  // Harness regfile: r0 reads zero, cleared by the same reset as the DUT.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  int zero_writes;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (preset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) regs[i] <= 32'h55;
    end else if (rf_we) begin
      if (rf_wreg == '0) zero_writes <= zero_writes + 1;
      else regs[rf_wreg] <= rf_wdata;
    end
  end

  logic [DATA_WIDTH-1:0] model_regs [NUM_REGS];
  bit                    model_drop;
  int                    model_count;
  logic [REG_BITS-1:0]   b_reg  [$];
  logic [DATA_WIDTH-1:0] b_data [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NUM_REGS); i++) model_regs[i] = '0;
    model_drop  = 1'b0;
    model_count = 0;
  endtask

  function automatic int regs_diff();
    int d = 0;
    for (int i = 0; i < int'(NUM_REGS); i++) if (regs[i] !== model_regs[i]) d++;
    return d;
  endfunction

  task automatic gen_beats(input int n);
    b_reg.delete();
    b_data.delete();
    for (int i = 0; i < n; i++) begin
      b_reg.push_back(REG_BITS'($urandom_range(NUM_REGS - 1, 0)));
      b_data.push_back(DATA_WIDTH'($urandom));
    end
  endtask

  task automatic start_and_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      check("clear_we", rf_we, 1);
      check("clear_reg", rf_wreg, i);
      check("clear_data", rf_wdata, 0);
      check("clear_status", {busy, done, cpu_reset, in_ready}, 4'b1010);
      cpu_we    = 1'b1;
      cpu_wreg  = REG_BITS'($urandom);
      cpu_wdata = DATA_WIDTH'($urandom);
      tick();
    end
    cpu_we = 1'b0;
    check("load_entry", {busy, in_ready, rf_we}, 3'b110);
    check("cleared_regs", regs_diff(), 0);
    check("cleared_flags", {r0_drop, load_count}, 0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps and stray starts
  task automatic stream(input int mode, input int stop_after);
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < b_reg.size() && i < stop_after && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(2, 0) != 0);
      endcase
      in_valid = v;
      in_reg   = v ? b_reg[i]  : REG_BITS'($urandom);
      in_data  = v ? b_data[i] : DATA_WIDTH'($urandom);
      in_last  = v ? (i == b_reg.size() - 1) : ($urandom_range(1, 0) == 1);
      start    = (mode == 2) ? ($urandom_range(1, 0) == 1) : 1'b0;
      check("load_ready", in_ready, 1);
      tick();
      check("beat_we", rf_we, v && (b_reg[i] != '0));
      if (v) begin
        if (b_reg[i] != '0) begin
          check("beat_wreg", rf_wreg, b_reg[i]);
          check("beat_wdata", rf_wdata, b_data[i]);
          model_regs[b_reg[i]] = b_data[i];
        end else begin
          model_drop = 1'b1;
        end
        if (model_count < 63) model_count++;
        i++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    check("stream_timeout", cyc < 4000, 1);
  endtask

  task automatic release_check();
    check("hold_entry", {cpu_reset, busy, done, in_ready}, 4'b1100);
    tick();
    for (int k = 1; k < RD; k++) begin
      check("hold", {cpu_reset, busy, done, rf_we}, 4'b1100);
      tick();
    end
    check("release", {cpu_reset, busy, done}, 3'b001);
    check("regs_after_load", regs_diff(), 0);
    check("r0_drop", r0_drop, model_drop);
    check("load_count", load_count, model_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b1; preset = 1'b0;
    in_valid = 1'b0; in_reg = '0; in_data = '0; in_last = 1'b0;
    cpu_we = 1'b0; cpu_wreg = '0; cpu_wdata = '0;
    repeat (3) tick();
    check("reset_wins", {busy, cpu_reset, rf_we}, 3'b010);
    reset = 1'b0;
    start = 1'b0;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      check("idle", {cpu_reset, rf_we, busy, done, in_ready}, 5'b10000);
      tick();
    end
    preset = 1'b1;
    tick();
    preset = 1'b0;

    start_and_clear();
    b_reg  = '{5'd5, 5'd0, 5'd5, 5'd31};
    b_data = '{32'd100, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    stream(0, 99);
    release_check();
    check("r5", regs[5], 32'hFFFF_FFFD);
    check("r31", regs[31], 32'hFFFF_FFFF);
    check("r0", regs[0], 0);
    check("drop_directed", r0_drop, 1);
    check("count_directed", load_count, 4);

    cpu_we = 1'b1; cpu_wreg = 5'd3; cpu_wdata = 32'd42;
    #1;
    check("pass_through", {rf_we, rf_wreg, rf_wdata}, {1'b1, 5'd3, 32'd42});
    tick();
    cpu_we = 1'b0;
    model_regs[3] = 32'd42;
    #1;
    check("cpu_write", regs[3], 42);
    check("pass_idle", rf_we, 0);

    start_and_clear();
    check("r3_cleared", regs[3], 0);
    gen_beats(6);
    stream(1, 99);
    release_check();

    for (int r = 0; r < 3; r++) begin
      start_and_clear();
      gen_beats(r == 2 ? 70 : int'($urandom_range(12, 1)));
      stream(2, 99);
      release_check();
    end

    start_and_clear();
    gen_beats(5);
    stream(0, 2);
    reset = 1'b1;
    in_valid = 1'b1; in_reg = 5'd9; in_data = 32'hDEAD;
    tick();
    model_clear();
    check("reset_mid", {cpu_reset, busy, done, in_ready, rf_we}, 5'b10000);
    check("reset_flags", {r0_drop, load_count}, 0);
    check("reset_regs", regs_diff(), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_we", {rf_we, in_ready, load_count}, 0);
    end
    in_valid = 1'b0;
    check("post_reset_regs", regs_diff(), 0);
    check("zero_writes", zero_writes, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
